// File: rtl/rle_pkg.sv
// Shared types and helpers for the parametrised run-length encoder.
// The record places the bit ID directly above the run-length field.
package rle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RD,
    COUNT,
    EMIT
  } state_e;

  // Distance of the bit-ID field from the record MSB.
  localparam int ID_MSB_OFS = 0;

  function automatic int rec_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/rle_enc_param_if.sv
// FIFO-side handshake bundle for the run-length encoder.
// master = encoder side, slave = FIFO/environment side.
interface rle_enc_param_if #(
  parameter int IN_W  = 8,
  parameter int CNT_W = 23
);

  logic                              recv_ready;
  logic                              rd_req;
  logic [IN_W-1:0]                   in_data;
  logic                              end_of_stream;
  logic                              send_ready;
  logic                              wr_req;
  logic [rle_pkg::rec_w(CNT_W)-1:0]  out_data;
  logic                              busy;

  modport master (
    input  recv_ready, in_data, end_of_stream, send_ready,
    output rd_req, wr_req, out_data, busy
  );

  modport slave (
    output recv_ready, in_data, end_of_stream, send_ready,
    input  rd_req, wr_req, out_data, busy
  );

endinterface

// File: rtl/rle_enc_param.sv
// Run-length encoder: fetches IN_W-bit words, scans LSB-first at one bit per clock,
// emits {bit ID, run length} records; stalls in EMIT while the output FIFO is full.
module rle_enc_param
  import rle_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int CNT_W  = 23,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  rle_enc_param_if.master   io
);

  localparam int REC_W  = rec_w(CNT_W);
  localparam int ID_POS = REC_W - 1 - ID_MSB_OFS;
  localparam int IDX_W  = $clog2(IN_W + 1);
  localparam int LAT_W  = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 value_type_q, value_type_d;
  logic [IN_W-1:0]      shift_buf_q, shift_buf_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 flush_q, flush_d;
  logic                 rd_req_q, rd_req_d;
  logic                 wr_req_q, wr_req_d;
  logic [REC_W-1:0]     out_data_q, out_data_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    value_type_d = value_type_q;
    shift_buf_d  = shift_buf_q;
    bit_idx_d    = bit_idx_q;
    lat_d        = lat_q;
    flush_d      = flush_q;
    out_data_d   = out_data_q;
    wr_req_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.recv_ready) begin
          state_d = REQ;
        end else if (io.end_of_stream && (count_q != '0)) begin
          flush_d = 1'b1;
          state_d = EMIT;
        end
      end

      REQ: begin
        lat_d   = '0;
        state_d = WAIT_RD;
      end

      WAIT_RD: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          shift_buf_d = io.in_data;
          bit_idx_d   = '0;
          state_d     = COUNT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      COUNT: begin
        // A run that is empty or still extendable absorbs the bit; otherwise close it first.
        if ((count_q == '0) || ((shift_buf_q[0] == value_type_q) && (count_q != MAX_CNT))) begin
          if (count_q == '0) begin
            value_type_d = shift_buf_q[0];
          end
          count_d     = count_q + CNT_W'(1);
          shift_buf_d = shift_buf_q >> 1;
          bit_idx_d   = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(IN_W - 1)) begin
            state_d = IDLE;
          end
        end else begin
          state_d = EMIT;
        end
      end

      EMIT: begin
        if (io.send_ready) begin
          out_data_d             = '0;
          out_data_d[ID_POS]     = value_type_q;
          out_data_d[CNT_W-1:0]  = count_q;
          wr_req_d               = 1'b1;
          count_d                = '0;
          if (flush_q || (bit_idx_q == IDX_W'(IN_W))) begin
            flush_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = COUNT;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    rd_req_d = (state_d == REQ);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      value_type_q <= 1'b0;
      shift_buf_q  <= '0;
      bit_idx_q    <= '0;
      lat_q        <= '0;
      flush_q      <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      value_type_q <= value_type_d;
      shift_buf_q  <= shift_buf_d;
      bit_idx_q    <= bit_idx_d;
      lat_q        <= lat_d;
      flush_q      <= flush_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
    end
  end

  assign io.rd_req   = rd_req_q;
  assign io.wr_req   = wr_req_q;
  assign io.out_data = out_data_q;
  assign io.busy     = busy_q;

endmodule

// File: tb/tb_rle_enc_param.sv
// Bench for rle_enc_param: instance 0 is the default build (CNT_W=23, RD_LAT=1),
// instance 1 a narrow saturating build (CNT_W=3, RD_LAT=2).
module tb_rle_enc_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  rle_enc_param_if #(.IN_W(8), .CNT_W(23)) ia ();
  rle_enc_param_if #(.IN_W(8), .CNT_W(3))  ib ();

  rle_enc_param #(.IN_W(8), .CNT_W(23), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst_a), .io(ia));
  rle_enc_param #(.IN_W(8), .CNT_W(3),  .RD_LAT(2)) dut_b (.clk(clk), .rst(rst_b), .io(ib));

  logic        rr [2];
  logic        eos[2];
  logic        sr [2];
  logic [7:0]  din[2];
  logic        rdq[2];
  logic        wrq[2];
  logic        bsy[2];
  logic [23:0] dout[2];

  assign ia.recv_ready    = rr[0];
  assign ia.in_data       = din[0];
  assign ia.end_of_stream = eos[0];
  assign ia.send_ready    = sr[0];
  assign ib.recv_ready    = rr[1];
  assign ib.in_data       = din[1];
  assign ib.end_of_stream = eos[1];
  assign ib.send_ready    = sr[1];
  assign rdq[0]  = ia.rd_req;
  assign wrq[0]  = ia.wr_req;
  assign bsy[0]  = ia.busy;
  assign dout[0] = ia.out_data;
  assign rdq[1]  = ib.rd_req;
  assign wrq[1]  = ib.wr_req;
  assign bsy[1]  = ib.busy;
  assign dout[1] = {20'b0, ib.out_data};

  logic [7:0]  wq[2][$];
  logic [23:0] eq[2][$];
  int rd_cnt[2];
  int wr_cnt[2];
  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0]  w;
    int          n;
    logic [23:0] r0, r1, r2;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic cond);
    checks++;
    if (cond !== 1'b1) begin
      fails++;
      $display("FAIL %s: condition got %b, expected 1", name, cond);
    end
  endtask

  function automatic logic [23:0] rec(input int i, input bit b, input int c);
    if (i == 0) return {b, c[22:0]};
    return {20'b0, b, c[2:0]};
  endfunction

  // Input FIFO model (data changes only on a read) plus output scoreboard.
  task automatic port_proc(input int i);
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rdq[i]) begin
        rd_cnt[i]++;
        chk1($sformatf("dut%0d_rd_req_with_data", i), wq[i].size() != 0);
        if (wq[i].size() != 0) din[i] = wq[i].pop_front();
      end
      rr[i] = (wq[i].size() != 0);
      if (wrq[i]) begin
        wr_cnt[i]++;
        chk1($sformatf("dut%0d_rd_wr_exclusive", i), !rdq[i]);
        if (eq[i].size() == 0) begin
          fails++;
          $display("FAIL dut%0d_unexpected_record: got %0h, expected none", i, dout[i]);
        end else begin
          e = eq[i].pop_front();
          chk($sformatf("dut%0d_record", i), dout[i], e);
        end
      end
    end
  endtask

  task automatic drain(input int i, input string name);
    int t;
    t = 0;
    while ((eq[i].size() != 0 || wq[i].size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk1({name, "_drained"}, t < 2000);
    repeat (3) @(negedge clk);
    chk({name, "_busy_idle"}, bsy[i], 0);
  endtask

  initial begin
    int rd0, wr0, t;
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rr[i] = 1'b0; eos[i] = 1'b0; sr[i] = 1'b1; din[i] = 8'h00;
      rd_cnt[i] = 0; wr_cnt[i] = 0;
    end
    fork
      port_proc(0);
      port_proc(1);
    join_none

    tbl[0] = '{8'hF0, 2, rec(0, 0, 4), rec(0, 1, 4), 24'h0};
    tbl[1] = '{8'h0F, 2, rec(0, 1, 4), rec(0, 0, 4), 24'h0};
    tbl[2] = '{8'h00, 1, rec(0, 0, 8), 24'h0,        24'h0};
    tbl[3] = '{8'hFF, 1, rec(0, 1, 8), 24'h0,        24'h0};
    tbl[4] = '{8'h81, 3, rec(0, 1, 1), rec(0, 0, 6), rec(0, 1, 1)};
    tbl[5] = '{8'h3C, 3, rec(0, 0, 2), rec(0, 1, 4), rec(0, 0, 2)};
    tbl[6] = '{8'h01, 2, rec(0, 1, 1), rec(0, 0, 7), 24'h0};

    repeat (3) @(negedge clk);
    chk("reset_rd_req",   rdq[0], 0);
    chk("reset_wr_req",   wrq[0], 0);
    chk("reset_out_data", dout[0], 0);
    chk("reset_busy",     bsy[0], 0);
    chk("reset_b_busy",   bsy[1], 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Single words with end_of_stream raised together with recv_ready.
    for (int k = 0; k < 7; k++) begin
      rd0 = rd_cnt[0];
      wr0 = wr_cnt[0];
      eq[0].push_back(tbl[k].r0);
      if (tbl[k].n > 1) eq[0].push_back(tbl[k].r1);
      if (tbl[k].n > 2) eq[0].push_back(tbl[k].r2);
      wq[0].push_back(tbl[k].w);
      eos[0] = 1'b1;
      drain(0, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d_rd_count", k), rd_cnt[0] - rd0, 1);
      chk($sformatf("vec%0d_wr_count", k), wr_cnt[0] - wr0, tbl[k].n);
      eos[0] = 1'b0;
      @(negedge clk);
    end

    // end_of_stream with an empty run emits nothing.
    wr0 = wr_cnt[0];
    rd0 = rd_cnt[0];
    eos[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("eos_empty_no_wr", wr_cnt[0] - wr0, 0);
    chk("eos_empty_no_rd", rd_cnt[0] - rd0, 0);
    chk("eos_empty_idle",  bsy[0], 0);
    eos[0] = 1'b0;
    @(negedge clk);

    // A run spanning two words.
    rd0 = rd_cnt[0];
    wr0 = wr_cnt[0];
    eq[0].push_back(rec(0, 0, 16));
    wq[0].push_back(8'h00);
    wq[0].push_back(8'h00);
    eos[0] = 1'b1;
    drain(0, "two_words");
    chk("two_words_rd_count", rd_cnt[0] - rd0, 2);
    chk("two_words_wr_count", wr_cnt[0] - wr0, 1);
    eos[0] = 1'b0;
    @(negedge clk);

    // Output backpressure at the first emit.
    wr0 = wr_cnt[0];
    sr[0] = 1'b0;
    eq[0].push_back(rec(0, 1, 4));
    eq[0].push_back(rec(0, 0, 4));
    wq[0].push_back(8'h0F);
    eos[0] = 1'b1;
    repeat (15) @(negedge clk);
    chk("bp_wr_withheld", wr_cnt[0] - wr0, 0);
    chk("bp_busy",        bsy[0], 1);
    sr[0] = 1'b1;
    drain(0, "bp");
    chk("bp_wr_count", wr_cnt[0] - wr0, 2);
    eos[0] = 1'b0;

    // Narrow counter: saturation splits runs, also across words.
    wr0 = wr_cnt[1];
    eq[1].push_back(rec(1, 1, 7));
    eq[1].push_back(rec(1, 1, 1));
    wq[1].push_back(8'hFF);
    eos[1] = 1'b1;
    drain(1, "sat_ff");
    chk("sat_ff_wr_count", wr_cnt[1] - wr0, 2);
    eos[1] = 1'b0;
    @(negedge clk);

    wr0 = wr_cnt[1];
    for (int k = 0; k < 3; k++) begin
      eq[1].push_back(rec(1, 1, 7));
      wq[1].push_back(8'hFF);
    end
    eq[1].push_back(rec(1, 1, 3));
    eos[1] = 1'b1;
    drain(1, "sat_24");
    chk("sat_24_wr_count", wr_cnt[1] - wr0, 4);
    eos[1] = 1'b0;
    @(negedge clk);

    // Reset while holding in EMIT drops the pending record.
    wr0 = wr_cnt[1];
    sr[1] = 1'b0;
    wq[1].push_back(8'h0F);
    repeat (15) @(negedge clk);
    chk("rst_pre_busy", bsy[1], 1);
    rst_b = 1'b0;
    #1;
    chk("rst_out_data", dout[1], 0);
    chk("rst_wr_req",   wrq[1], 0);
    chk("rst_rd_req",   rdq[1], 0);
    chk("rst_busy",     bsy[1], 0);
    @(negedge clk);
    rst_b = 1'b1;
    sr[1] = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_wr", wr_cnt[1] - wr0, 0);

    eq[1].push_back(rec(1, 1, 1));
    eq[1].push_back(rec(1, 0, 7));
    wq[1].push_back(8'h01);
    eos[1] = 1'b1;
    t = 0;
    while (!rdq[1] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk1("rst_next_rd_seen", rdq[1]);
    t = 0;
    while (!wrq[1] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_rd_to_wr_cycles", t, 6);
    drain(1, "rst_next");
    eos[1] = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rle_enc_param.md
Name: rle_enc_param

Overview:
Parametrised run-length encoder for bit streams, and the successor to the fixed 8-bit/23-bit encoder. It pulls IN_W-bit words from an input-side FIFO and scans them LSB-first, one bit per clock. It pushes {bit ID, run length} records to an output-side FIFO. New in this block: configurable word and count widths, configurable FIFO read latency, saturating runs that split at the maximum count, and a clean flush that never emits a zero-length record.

Parameters:
IN_W, 8, input word width in bits (>=1)
CNT_W, 23, run-length counter width; record width is CNT_W+1
RD_LAT, 1, cycles from the rd_req cycle to the cycle in which in_data is valid (>=1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
recv_ready  in  1  input FIFO not empty
rd_req  out  1  input FIFO read request, one-cycle pulse per word
in_data  in  IN_W  input FIFO read data
end_of_stream  in  1  level; stream ended, flush the pending run
send_ready  in  1  output FIFO not full
wr_req  out  1  output FIFO write request, one-cycle pulse per record
out_data  out  CNT_W+1  [CNT_W] = bit ID, [CNT_W-1:0] = run length
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE and clears rd_req, wr_req, out_data, busy, run count, value_type, shift_buf, bit index and flush flag to 0. Reset asserted in any state, including mid-EMIT, aborts the state and drops any pending record.
- All outputs are registered. MAX = 2^CNT_W - 1.
- States: IDLE, REQ, WAIT_RD, COUNT, EMIT.
- IDLE:
  - If recv_ready = 1, go to REQ. recv_ready takes priority over end_of_stream.
  - Otherwise, if end_of_stream = 1 and count != 0, set flush and go to EMIT.
  - Otherwise, if end_of_stream = 1 and count == 0, stay in IDLE and emit nothing.
- REQ: rd_req = 1 for exactly this cycle; go to WAIT_RD.
- WAIT_RD:
  - Count RD_LAT cycles.
  - In the RD_LAT-th cycle after REQ, capture in_data into shift_buf, clear the bit index and go to COUNT.
- COUNT: examine shift_buf[0] each cycle.
  - Run empty (count == 0): value_type <= bit; count <= 1; consume.
  - bit == value_type and count < MAX: count++; consume.
  - bit != value_type or count == MAX: go to EMIT without consuming.
  - Consume means shift_buf >>= 1 and index++. If the consumed bit was index IN_W-1, go to IDLE.
  - Runs persist across words: the count is not cleared when a new word is fetched.
- EMIT:
  - Hold while send_ready = 0; no bits are consumed.
  - On the first cycle with send_ready = 1: out_data <= {value_type, count}, wr_req pulses high for the next cycle only, and count <= 0.
  - Then go to IDLE if flush is set (clear flush) or if the word is exhausted; otherwise go back to COUNT.
  - out_data holds the last record until the next emit.
- end_of_stream is sampled only in IDLE. Assertion mid-word takes effect after the word is consumed.
- Saturation: a run of L bits produces floor(L/MAX) records of MAX plus one record of the remainder if it is nonzero, all with the same bit ID.
- Throughput: 1 bit per clock in COUNT. Each word costs 2+RD_LAT cycles of fetch overhead. Each record costs at least 1 EMIT cycle.
- rd_req is never asserted when recv_ready is 0 in the preceding IDLE cycle. rd_req and wr_req are never high together.

Decomposition:
- Package rle_pkg holds:
  - the state enum (IDLE, REQ, WAIT_RD, COUNT, EMIT);
  - the function rec_w(CNT_W) = CNT_W+1;
  - the constant for the bit-ID field position.
- No sub-module is required. Fetch and scan share a single FSM, and splitting them would add a handshake without benefit.

Test Plan:
- 8'hF0 then end_of_stream, send_ready = 1 -> records {0,4}, {1,4}; then IDLE, busy = 0.
- CNT_W = 3, 8'hFF then end_of_stream -> records {1,7}, {1,1}; no zero-length record.
- Words 8'h00, 8'h00, then end_of_stream -> single record {0,16}, with rd_req pulsed twice.
- 8'h0F with send_ready held low for 5 cycles at the first emit -> wr_req withheld, shift_buf unchanged; after release, records {1,4}, {0,4}.
- end_of_stream with count 0 -> no wr_req. recv_ready and end_of_stream high together -> the word is read first and flushed afterwards.
- rst driven low mid-EMIT, RD_LAT = 2 -> outputs 0 immediately, no wr_req. After release, the next word gives rd_req then capture 2 cycles later.
